// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: FSM state encoding and default parameters for the SRAM arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_W    = 18;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_WAIT_CYC  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick, searching from one past the last granted port
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = ptr;
    j = ptr;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sram_arb.sv
// sram_arb: round-robin arbiter giving NUM_PORTS requesters one access at a time
// to an asynchronous SRAM built from 16-bit chips
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wd,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [DATA_W-1:0]             rd,
  output logic                          xonOE,
  output logic                          xonWE,
  output logic [ADDR_W-1:0]             xopAddr,
  output logic [DATA_W/16-1:0]          xonCE,
  output logic [DATA_W/16-1:0]          xonUB,
  output logic [DATA_W/16-1:0]          xonLB,
  inout  wire  [DATA_W-1:0]             xbpDATA
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int LN = DATA_W / 16;
  localparam int BW = DATA_W / 8;
  localparam int CW = $clog2(WAIT_CYC + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_idx;
  logic [NUM_PORTS-1:0] g_oh;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d, rd_q, rd_d;
  logic [BW-1:0] be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic grant, last_acc, busy;
  logic [ADDR_W-1:0] addr_a [NUM_PORTS];
  logic [DATA_W-1:0] wd_a [NUM_PORTS];
  logic [BW-1:0] be_a [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign addr_a[i] = addr[i*ADDR_W +: ADDR_W];
    assign wd_a[i]   = wd[i*DATA_W +: DATA_W];
    assign be_a[i]   = be[i*BW +: BW];
  end
  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .req  (req),
    .ptr  (ptr_q),
    .grant(g_oh),
    .idx  (g_idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_PORTS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end
  always_comb begin
    grant    = state_q == IDLE && |g_oh;
    last_acc = state_q == ACCESS && cnt_q == CW'(1);
    state_d  = state_q == IDLE   ? (grant ? SETUP : IDLE) :
               state_q == SETUP  ? ACCESS :
               state_q == ACCESS ? (last_acc ? DONE : ACCESS) : IDLE;
  end
  // The whole request is captured at grant so requesters may change inputs afterwards
  always_comb begin
    ptr_d  = grant ? g_idx : ptr_q;
    we_d   = grant ? we[g_idx] : we_q;
    addr_d = grant ? addr_a[g_idx] : addr_q;
    wd_d   = grant ? wd_a[g_idx] : wd_q;
    be_d   = grant ? be_a[g_idx] : be_q;
    cnt_d  = state_q == SETUP ? CW'(WAIT_CYC) : state_q == ACCESS ? cnt_q - CW'(1) : cnt_q;
    rd_d   = last_acc && !we_q ? xbpDATA : rd_q;
  end
  always_comb begin
    busy    = state_q != IDLE;
    ack     = state_q == DONE ? NUM_PORTS'(1) << ptr_q : '0;
    xonCE   = busy ? '0 : '1;
    xonOE   = !(!we_q && (state_q == SETUP || state_q == ACCESS));
    xonWE   = !(we_q && state_q == ACCESS);
    xopAddr = addr_q;
    rd      = rd_q;
    xonUB   = '1;
    xonLB   = '1;
    for (int k = 0; k < LN; k++) begin
      xonUB[k] = busy ? we_q & ~be_q[2*k+1] : 1'b1;
      xonLB[k] = busy ? we_q & ~be_q[2*k] : 1'b1;
    end
  end
  // Write data spans SETUP..DONE for hold margin; the IDLE after DONE is the turnaround
  assign xbpDATA = busy && we_q ? wd_q : 'z;
endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed and randomized checks of sram_arb against a transaction-level model
module tb_sram_arb;
  localparam int NP = 2;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int WC = 2;
  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] req, we, ack;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wd;
  logic [NP*DW/8-1:0] be;
  logic [DW-1:0] rd;
  logic xonOE, xonWE;
  logic [AW-1:0] xopAddr;
  logic [1:0] xonCE, xonUB, xonLB;
  wire [DW-1:0] xbpDATA;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int total = 0;
  int bad = 0;
  int last_g = NP - 1;
  always #5 clk = ~clk;
  sram_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd), .be(be),
    .ack(ack), .rd(rd), .xonOE(xonOE), .xonWE(xonWE), .xopAddr(xopAddr),
    .xonCE(xonCE), .xonUB(xonUB), .xonLB(xonLB), .xbpDATA(xbpDATA)
  );
  // SRAM chips: drive on OE low, latch lanes selected by UB/LB while WE low
  assign xbpDATA = (xonCE == 2'b00 && !xonOE && xonWE) ? mem[xopAddr[7:0]] : 'z;
  always @(negedge clk) begin
    if (!rst && !xonWE && xonCE == 2'b00) begin
      for (int k = 0; k < 2; k++) begin
        if (!xonLB[k]) mem[xopAddr[7:0]][16*k +: 8] = xbpDATA[16*k +: 8];
        if (!xonUB[k]) mem[xopAddr[7:0]][16*k+8 +: 8] = xbpDATA[16*k+8 +: 8];
      end
    end
  end
  task tick;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    rst = 1'b1; req = '0; we = '0; addr = '0; wd = '0; be = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({xonOE, xonWE} !== 2'b11) begin bad++; $display("FAIL reset_oe_we got=%b want=11", {xonOE, xonWE}); end
    total++; if (xonCE !== 2'b11) begin bad++; $display("FAIL reset_ce got=%b want=11", xonCE); end
    total++; if ({xonUB, xonLB} !== 4'b1111) begin bad++; $display("FAIL reset_ub_lb got=%b want=1111", {xonUB, xonLB}); end
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", ack); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h want=0", rd); end
    total++; if (xopAddr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", xopAddr); end
    rst = 1'b0;
    tick;
  endtask
  task automatic run_single(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] b, input logic [DW-1:0] exp_rd);
    logic [1:0] ea;
    logic [3:0] es;
    logic [3:0] eub;
    req = '0; req[p] = 1'b1; we[p] = w; addr[p*AW +: AW] = a; wd[p*DW +: DW] = d; be[p*4 +: 4] = b;
    for (int k = 1; k <= 5; k++) begin
      tick;
      if (k == 1) begin
        we[p] = ~w; addr[p*AW +: AW] = ~a; wd[p*DW +: DW] = ~d; be[p*4 +: 4] = ~b;
      end
      ea = k == 4 ? 2'(1 << p) : 2'b00;
      total++; if (ack !== ea) begin bad++; $display("FAIL single_ack k=%0d got=%b want=%b", k, ack, ea); end
      es = {k <= 4 ? 2'b00 : 2'b11, (!w && k <= 3) ? 1'b0 : 1'b1, (w && (k == 2 || k == 3)) ? 1'b0 : 1'b1};
      total++; if ({xonCE, xonOE, xonWE} !== es) begin bad++; $display("FAIL single_strobes k=%0d ce_oe_we got=%b want=%b", k, {xonCE, xonOE, xonWE}, es); end
      total++; if (xopAddr !== a) begin bad++; $display("FAIL single_addr k=%0d got=%h want=%h", k, xopAddr, a); end
      if (k <= 4) begin
        eub = w ? ~{b[3], b[1], b[2], b[0]} : 4'b0000;
        total++; if ({xonUB, xonLB} !== eub) begin bad++; $display("FAIL single_ub_lb k=%0d got=%b want=%b", k, {xonUB, xonLB}, eub); end
        if (w) begin
          total++; if (xbpDATA !== d) begin bad++; $display("FAIL single_wdata k=%0d got=%h want=%h", k, xbpDATA, d); end
        end
      end
      if (k == 4 && !w) begin
        total++; if (rd !== exp_rd) begin bad++; $display("FAIL single_rd got=%h want=%h", rd, exp_rd); end
      end
      if (k == 4) req[p] = 1'b0;
    end
    last_g = p;
  endtask
  task test_write;
    run_single(0, 1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, 32'h0);
    ref_mem[16] = 32'hDEADBEEF;
  endtask
  task test_read;
    run_single(1, 1'b0, 18'h00010, 32'h0, 4'h0, 32'hDEADBEEF);
  endtask
  task test_byte_enable;
    run_single(0, 1'b1, 18'h00010, 32'h11223344, 4'h5, 32'h0);
    ref_mem[16] = 32'hDE22BE44;
    run_single(0, 1'b0, 18'h00010, 32'h0, 4'h0, 32'hDE22BE44);
  endtask
  task test_back_to_back;
    int ep;
    logic [1:0] ea;
    req = 2'b11; we = 2'b00; addr = {18'h00010, 18'h00010};
    ep = (last_g + 1) % NP;
    for (int k = 1; k <= 20; k++) begin
      tick;
      ea = k % 5 == 4 ? 2'(1 << ep) : 2'b00;
      total++; if (ack !== ea) begin bad++; $display("FAIL b2b_ack k=%0d got=%b want=%b", k, ack, ea); end
      if (k % 5 == 4) begin
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL b2b_rd k=%0d got=%h want=DE22BE44", k, rd); end
        last_g = ep;
        ep = (ep + 1) % NP;
      end
      if (k == 19) req = 2'b00;
    end
  endtask
  task test_reset_mid;
    logic got;
    req = 2'b10; we = 2'b10; addr[AW +: AW] = 18'h000FF; wd[DW +: DW] = 32'hCAFEF00D; be[4 +: 4] = 4'hF;
    tick;
    tick;
    total++; if (xonWE !== 1'b0) begin bad++; $display("FAIL rmid_we_before got=%b want=0", xonWE); end
    rst = 1'b1;
    #1;
    total++; if ({xonWE, xonOE, xonCE} !== 4'b1111) begin bad++; $display("FAIL rmid_strobes got=%b want=1111", {xonWE, xonOE, xonCE}); end
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL rmid_ack got=%b want=00", ack); end
    tick;
    rst = 1'b0;
    last_g = NP - 1;
    req = 2'b11; we = 2'b00; addr = {18'h00010, 18'h00010};
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick;
      if (ack !== 2'b00) begin
        got = 1'b1;
        total++; if (ack !== 2'b01 || c != 3) begin bad++; $display("FAIL rmid_next_grant got=%b at %0d want=01 at 3", ack, c); end
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL rmid_rd got=%h want=DE22BE44", rd); end
      end
    end
    if (!got) begin total++; bad++; $display("FAIL rmid_timeout got=no_ack want=ack"); end
    req = 2'b00;
    last_g = 0;
    tick;
  endtask
  task test_random;
    logic [NP-1:0] pend;
    logic t_we [NP];
    logic [AW-1:0] t_addr [NP];
    logic [DW-1:0] t_wd [NP];
    logic [3:0] t_be [NP];
    logic have, inflight, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, m;
    logic [3:0] g_be, es, eub;
    logic [1:0] ea;
    int gcyc, cur, age;
    have = 1'b0; gcyc = 0; cur = 0; pend = '0; g_we = 1'b0; g_addr = '0; g_wd = '0; g_be = '0;
    for (int c = 0; c < 600; c++) begin
      age = c - gcyc;
      inflight = have && age >= 1 && age <= 4;
      ea = (have && age == 4) ? 2'(1 << cur) : 2'b00;
      total++; if (ack !== ea) begin bad++; $display("FAIL rand_ack c=%0d got=%b want=%b", c, ack, ea); end
      es = {inflight ? 2'b00 : 2'b11, (inflight && !g_we && age <= 3) ? 1'b0 : 1'b1,
            (inflight && g_we && (age == 2 || age == 3)) ? 1'b0 : 1'b1};
      total++; if ({xonCE, xonOE, xonWE} !== es) begin bad++; $display("FAIL rand_strobes c=%0d ce_oe_we got=%b want=%b", c, {xonCE, xonOE, xonWE}, es); end
      total++; if (!xonWE && (!xonOE || xonCE != 2'b00)) begin bad++; $display("FAIL rand_overlap c=%0d got=%b want=no_overlap", c, {xonCE, xonOE, xonWE}); end
      if (inflight) begin
        total++; if (xopAddr !== g_addr) begin bad++; $display("FAIL rand_addr c=%0d got=%h want=%h", c, xopAddr, g_addr); end
        eub = g_we ? ~{g_be[3], g_be[1], g_be[2], g_be[0]} : 4'b0000;
        total++; if ({xonUB, xonLB} !== eub) begin bad++; $display("FAIL rand_ub_lb c=%0d got=%b want=%b", c, {xonUB, xonLB}, eub); end
        if (g_we) begin
          total++; if (xbpDATA !== g_wd) begin bad++; $display("FAIL rand_wdata c=%0d got=%h want=%h", c, xbpDATA, g_wd); end
        end
      end
      if (have && age == 4) begin
        if (g_we) begin
          m = ref_mem[g_addr[7:0]];
          for (int b = 0; b < 4; b++) if (g_be[b]) m[8*b +: 8] = g_wd[8*b +: 8];
          ref_mem[g_addr[7:0]] = m;
        end else begin
          total++; if (rd !== ref_mem[g_addr[7:0]]) begin bad++; $display("FAIL rand_rd c=%0d got=%h want=%h", c, rd, ref_mem[g_addr[7:0]]); end
        end
        pend[cur] = 1'b0;
      end
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          t_we[p] = 1'($urandom_range(0, 1));
          t_addr[p] = AW'($urandom_range(0, 254));
          t_wd[p] = $urandom;
          t_be[p] = 4'($urandom_range(0, 15));
        end
        req[p] = pend[p];
        if (have && p == cur && age >= 1 && age <= 3) begin
          we[p] = 1'($urandom_range(0, 1)); addr[p*AW +: AW] = AW'($urandom);
          wd[p*DW +: DW] = $urandom; be[p*4 +: 4] = 4'($urandom_range(0, 15));
        end else begin
          we[p] = t_we[p]; addr[p*AW +: AW] = t_addr[p]; wd[p*DW +: DW] = t_wd[p]; be[p*4 +: 4] = t_be[p];
        end
      end
      if ((!have || age >= 5) && req != '0) begin
        cur = (last_g + 1) % NP;
        while (!req[cur]) cur = (cur + 1) % NP;
        have = 1'b1; gcyc = c; last_g = cur;
        g_we = t_we[cur]; g_addr = t_addr[cur]; g_wd = t_wd[cur]; g_be = t_be[cur];
      end
      tick;
    end
    req = '0;
    repeat (6) tick;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    test_reset;
    test_write;
    test_read;
    test_byte_enable;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameters SHALL be:
- NUM_PORTS, 2, requester count (2..8)
- ADDR_W, 18, SRAM word-address width
- DATA_W, 32, data width, multiple of 16 (one 16-bit chip per lane)
- WAIT_CYC, 2, access-strobe cycles (>=1)
REQ-002 Ports SHALL be (clock and reset first; clk is the single clock; rst is asynchronous, active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  NUM_PORTS  per-port request
- we  in  NUM_PORTS  per-port write (1) / read (0)
- addr  in  NUM_PORTS*ADDR_W  packed per-port address
- wd  in  NUM_PORTS*DATA_W  packed per-port write data
- be  in  NUM_PORTS*DATA_W/8  packed per-port write byte enables, active-high
- ack  out  NUM_PORTS  one-cycle completion pulse
- rd  out  DATA_W  read data, shared by all ports
- xonOE  out  1  SRAM output enable, active-low
- xonWE  out  1  SRAM write enable, active-low
- xopAddr  out  ADDR_W  SRAM address
- xonCE  out  DATA_W/16  per-chip enable, active-low
- xonUB  out  DATA_W/16  per-chip upper-byte enable, active-low
- xonLB  out  DATA_W/16  per-chip lower-byte enable, active-low
- xbpDATA  inout  DATA_W  SRAM data bus; chip k uses bits [16k+15:16k]

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS, DONE. Transitions: IDLE->SETUP when any req is high; SETUP->ACCESS after 1 cycle; ACCESS->DONE after WAIT_CYC cycles; DONE->IDLE after 1 cycle.
REQ-004 In IDLE, the arbiter SHALL grant round-robin, starting at (last granted + 1) mod NUM_PORTS.
REQ-005 On grant, the block SHALL latch port index, we, addr, wd and be; later input changes SHALL NOT affect the access in flight.
REQ-006 xopAddr SHALL be driven from the latched address in SETUP, ACCESS and DONE, and hold its last value in IDLE.
REQ-007 xonCE SHALL be all-0 in SETUP, ACCESS and DONE, and all-1 in IDLE.
REQ-008 Reads: xonOE SHALL be 0 in SETUP and ACCESS, and 1 otherwise; xonUB and xonLB SHALL be all-0; xbpDATA SHALL be hi-Z.
REQ-009 Reads: xbpDATA SHALL be registered into rd on the final ACCESS cycle.
REQ-010 Writes: xonWE SHALL be 0 only in ACCESS; xonOE SHALL stay 1; xbpDATA SHALL drive the latched wd in SETUP, ACCESS and DONE (setup/hold margin).
REQ-011 Writes: xonUB[k] SHALL equal ~be[2k+1] and xonLB[k] SHALL equal ~be[2k] during SETUP, ACCESS and DONE.
REQ-012 ack[granted] SHALL pulse high for exactly the DONE cycle; ack SHALL be all-0 otherwise.
REQ-013 For reads, rd SHALL be valid in the DONE cycle and hold until the next read capture.
REQ-014 Latency SHALL be WAIT_CYC+2 cycles from the grant edge to ack; throughput SHALL be one access per WAIT_CYC+3 cycles.
REQ-015 DONE->IDLE SHALL always insert the idle cycle; this cycle is the bus turnaround, so the block never drives xbpDATA while xonOE=0.
REQ-016 A requester SHALL hold req until ack; req dropped before ack SHALL NOT abort the access in flight.
REQ-017 A requester that keeps req high after ack SHALL be re-arbitrated in the next IDLE.
REQ-018 The wait counter SHALL be $clog2(WAIT_CYC+1) bits wide, load in SETUP and count down in ACCESS.

Reset
REQ-019 While rst=1, asynchronously: state=IDLE; xonOE, xonWE, xonCE, xonUB, xonLB all 1; xbpDATA hi-Z; ack=0; rd=0; xopAddr=0; rr pointer=NUM_PORTS-1 (so port 0 wins first).
REQ-020 Reset mid-access SHALL abandon the access with no ack, and the strobes SHALL rise in the same cycle.

Structure
REQ-021 Package sram_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-022 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, pointer; outputs one-hot grant and index).

Verification (NUM_PORTS=2, DATA_W=32, WAIT_CYC=2)
REQ-023 Port0 write addr=0x00010, wd=0xDEADBEEF, be=0xF -> WE low for 2 cycles, data driven from SETUP to DONE, ack[0] at grant+4.
REQ-024 Port1 read addr=0x00010 after REQ-023 -> OE low for 3 cycles, xbpDATA hi-Z, rd=0xDEADBEEF with ack[1].
REQ-025 Both ports request continuously -> grants alternate 0,1,0,1, one ack every 5 cycles, never both acks together.
REQ-026 Write be=0x5 -> xonLB=2'b00 and xonUB=2'b11 during the access; a later read returns only bytes 0 and 2 updated.
REQ-027 rst asserted on the first ACCESS cycle -> WE/OE/CE high immediately, no ack, next grant goes to port 0.
REQ-028 Checker: xonOE=0 and block driving xbpDATA SHALL never coincide; xonWE=0 SHALL only occur with xonCE=0.
